jtframe_rom_req: RTL and testbench



---
 rtl/jtframe_rom_req_pkg.sv | 11 +
 rtl/jtframe_rom_req_slot.sv | 41 ++++
 rtl/jtframe_rom_req.sv | 119 +++++++++++
 tb/tb_jtframe_rom_req.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_rom_req_pkg.sv
// Shared types and widths for the two-slot ROM request cache.
package jtframe_rom_req_pkg;
    localparam int AW = 22;
    localparam int DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_WAIT_RDY = 2'd2
    } state_t;
endpackage

// File: rtl/jtframe_rom_req_slot.sv
// One cache slot: data word, tag, valid bit and hit logic.
module jtframe_rom_req_slot
    import jtframe_rom_req_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_inv,
    input  logic          i_wr,
    input  logic [AW-1:0] i_tag,
    input  logic [DW-1:0] i_data,
    input  logic          i_cs,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] o_dout,
    output logic          o_ok,
    output logic          o_miss
);
    logic [DW-1:0] r_data;
    logic [AW-1:0] r_tag;
    logic          r_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_tag   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_wr) begin
                r_data <= i_data;
                r_tag  <= i_tag;
            end
            // The register is about to be overwritten, so stop hitting on it
            if (i_clr || i_inv) r_valid <= 1'b0;
            else if (i_wr)      r_valid <= 1'b1;
        end
    end

    assign o_dout = r_data;
    assign o_ok   = i_cs && r_valid && (r_tag == i_addr);
    assign o_miss = i_cs && !o_ok;
endmodule

// File: rtl/jtframe_rom_req.sv
// Two-slot ROM read cache arbitrating SDRAM fetches (slot0 has priority).
module jtframe_rom_req
    import jtframe_rom_req_pkg::*;
#(
    parameter logic [AW-1:0] SLOT0_OFFSET = 22'h0,
    parameter logic [AW-1:0] SLOT1_OFFSET = 22'h0
) (
    input  logic          clk_rom,
    input  logic          rst_n,
    input  logic          downloading,
    input  logic          loop_rst,
    input  logic          slot0_cs,
    input  logic [AW-1:0] slot0_addr,
    output logic [DW-1:0] slot0_dout,
    output logic          slot0_ok,
    input  logic          slot1_cs,
    input  logic [AW-1:0] slot1_addr,
    output logic [DW-1:0] slot1_dout,
    output logic          slot1_ok,
    output logic          sdram_req,
    input  logic          sdram_ack,
    output logic [AW-1:0] sdram_addr,
    input  logic [DW-1:0] data_read,
    input  logic          data_rdy,
    output logic          refresh_en
);
    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_tag;
    logic          r_sel;
    logic          r_drop;
    logic          w_miss0;
    logic          w_miss1;
    logic          w_start;
    logic          w_store;
    logic          w_clr;

    always_ff @(posedge clk_rom) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:
                if ((w_miss0 || w_miss1) && !downloading)
                    w_next = ST_WAIT_ACK;
            ST_WAIT_ACK:
                if (sdram_ack) w_next = ST_WAIT_RDY;
            ST_WAIT_RDY:
                if (data_rdy) w_next = ST_IDLE;
            default:
                w_next = ST_IDLE;
        endcase
        if (loop_rst) w_next = ST_IDLE;
    end

    always_comb begin
        w_start    = (r_state == ST_IDLE) && (w_next == ST_WAIT_ACK);
        w_store    = (r_state == ST_WAIT_RDY) && data_rdy && !loop_rst
                     && !downloading && !r_drop;
        w_clr      = loop_rst || downloading;
        sdram_req  = (r_state == ST_WAIT_ACK);
        refresh_en = (r_state == ST_IDLE) && !w_miss0 && !w_miss1
                     && !downloading;
    end

    // A fetch that overlapped a download must not be cached
    always_ff @(posedge clk_rom) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_tag  <= '0;
            r_sel  <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            if (w_start) begin
                r_sel  <= !w_miss0;
                r_tag  <= w_miss0 ? slot0_addr : slot1_addr;
                r_addr <= w_miss0 ? slot0_addr + SLOT0_OFFSET
                                  : slot1_addr + SLOT1_OFFSET;
            end
            r_drop <= (r_state != ST_IDLE) && (r_drop || downloading);
        end
    end

    assign sdram_addr = r_addr;

    jtframe_rom_req_slot u_slot0 (
        .clk    (clk_rom),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_inv  (w_start && w_miss0),
        .i_wr   (w_store && !r_sel),
        .i_tag  (r_tag),
        .i_data (data_read),
        .i_cs   (slot0_cs),
        .i_addr (slot0_addr),
        .o_dout (slot0_dout),
        .o_ok   (slot0_ok),
        .o_miss (w_miss0)
    );

    jtframe_rom_req_slot u_slot1 (
        .clk    (clk_rom),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_inv  (w_start && !w_miss0),
        .i_wr   (w_store && r_sel),
        .i_tag  (r_tag),
        .i_data (data_read),
        .i_cs   (slot1_cs),
        .i_addr (slot1_addr),
        .o_dout (slot1_dout),
        .o_ok   (slot1_ok),
        .o_miss (w_miss1)
    );
endmodule

// File: tb/tb_jtframe_rom_req.sv
// Directed bench for jtframe_rom_req with hand-computed expectations.
module tb_jtframe_rom_req;
    logic        clk_rom = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic        loop_rst = 1'b0;
    logic        slot0_cs = 1'b0;
    logic [21:0] slot0_addr = '0;
    logic [31:0] slot0_dout;
    logic        slot0_ok;
    logic        slot1_cs = 1'b0;
    logic [21:0] slot1_addr = '0;
    logic [31:0] slot1_dout;
    logic        slot1_ok;
    logic        sdram_req;
    logic        sdram_ack = 1'b0;
    logic [21:0] sdram_addr;
    logic [31:0] data_read = '0;
    logic        data_rdy = 1'b0;
    logic        refresh_en;

    int total = 0;
    int passed = 0;

    always #5 clk_rom = ~clk_rom;

    jtframe_rom_req #(
        .SLOT0_OFFSET(22'h10000),
        .SLOT1_OFFSET(22'h3FFFFF)
    ) dut (
        .clk_rom     (clk_rom),
        .rst_n       (rst_n),
        .downloading (downloading),
        .loop_rst    (loop_rst),
        .slot0_cs    (slot0_cs),
        .slot0_addr  (slot0_addr),
        .slot0_dout  (slot0_dout),
        .slot0_ok    (slot0_ok),
        .slot1_cs    (slot1_cs),
        .slot1_addr  (slot1_addr),
        .slot1_dout  (slot1_dout),
        .slot1_ok    (slot1_ok),
        .sdram_req   (sdram_req),
        .sdram_ack   (sdram_ack),
        .sdram_addr  (sdram_addr),
        .data_read   (data_read),
        .data_rdy    (data_rdy),
        .refresh_en  (refresh_en)
    );

    task automatic tick();
        @(posedge clk_rom);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ok0", {31'd0, slot0_ok}, 32'd0);
        chk("rst_ok1", {31'd0, slot1_ok}, 32'd0);
        chk("rst_dout0", slot0_dout, 32'd0);
        chk("rst_dout1", slot1_dout, 32'd0);
        chk("rst_req", {31'd0, sdram_req}, 32'd0);
        chk("rst_addr", {10'd0, sdram_addr}, 32'd0);
        chk("rst_refresh", {31'd0, refresh_en}, 32'd1);
        rst_n = 1'b1;

        // basic fetch with offset
        slot0_cs = 1'b1;
        slot0_addr = 22'h1234;
        #1;
        chk("miss_refresh", {31'd0, refresh_en}, 32'd0);
        tick();
        chk("f1_req", {31'd0, sdram_req}, 32'd1);
        chk("f1_addr", {10'd0, sdram_addr}, 32'h11234);
        tick();
        chk("f1_req_hold", {31'd0, sdram_req}, 32'd1);
        chk("f1_addr_hold", {10'd0, sdram_addr}, 32'h11234);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        chk("f1_req_drop", {31'd0, sdram_req}, 32'd0);
        chk("f1_ok_wait", {31'd0, slot0_ok}, 32'd0);
        data_rdy = 1'b1;
        data_read = 32'hDEADBEEF;
        tick();
        data_rdy = 1'b0;
        chk("f1_ok", {31'd0, slot0_ok}, 32'd1);
        chk("f1_dout", slot0_dout, 32'hDEADBEEF);
        chk("hit_refresh", {31'd0, refresh_en}, 32'd1);

        // address change and change back during fetch
        slot0_addr = 22'h1236;
        #1;
        chk("chg_ok_drop", {31'd0, slot0_ok}, 32'd0);
        tick();
        chk("chg_addr", {10'd0, sdram_addr}, 32'h11236);
        slot0_addr = 22'h1234;
        #1;
        chk("back_ok_low", {31'd0, slot0_ok}, 32'd0);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy = 1'b1;
        data_read = 32'h11111236;
        tick();
        data_rdy = 1'b0;
        chk("back_ok_after", {31'd0, slot0_ok}, 32'd0);
        chk("back_req_idle", {31'd0, sdram_req}, 32'd0);
        tick();
        chk("refetch_req", {31'd0, sdram_req}, 32'd1);
        chk("refetch_addr", {10'd0, sdram_addr}, 32'h11234);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy = 1'b1;
        data_read = 32'h22221234;
        tick();
        data_rdy = 1'b0;
        chk("refetch_ok", {31'd0, slot0_ok}, 32'd1);
        chk("refetch_dout", slot0_dout, 32'h22221234);

        // both slots miss; slot0 first, slot1 wraps its offset
        slot0_addr = 22'h2000;
        slot1_cs = 1'b1;
        slot1_addr = 22'h2;
        tick();
        chk("arb_addr0", {10'd0, sdram_addr}, 32'h12000);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy = 1'b1;
        data_read = 32'hA0A0A0A0;
        tick();
        data_rdy = 1'b0;
        chk("arb_ok0", {31'd0, slot0_ok}, 32'd1);
        chk("arb_ok1_low", {31'd0, slot1_ok}, 32'd0);
        chk("arb_req_idle", {31'd0, sdram_req}, 32'd0);
        tick();
        chk("arb_req1", {31'd0, sdram_req}, 32'd1);
        chk("wrap_addr", {10'd0, sdram_addr}, 32'h1);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy = 1'b1;
        data_read = 32'hB1B1B1B1;
        tick();
        data_rdy = 1'b0;
        chk("arb_ok1", {31'd0, slot1_ok}, 32'd1);
        chk("arb_dout1", slot1_dout, 32'hB1B1B1B1);

        // loop_rst in WAIT_RDY, then stray data_rdy
        slot0_addr = 22'h3000;
        tick();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        loop_rst = 1'b1;
        slot0_cs = 1'b0;
        slot1_cs = 1'b0;
        tick();
        loop_rst = 1'b0;
        chk("lrst_req", {31'd0, sdram_req}, 32'd0);
        chk("lrst_refresh", {31'd0, refresh_en}, 32'd1);
        data_rdy = 1'b1;
        data_read = 32'h5A5A5A5A;
        tick();
        data_rdy = 1'b0;
        slot0_cs = 1'b1;
        slot1_cs = 1'b1;
        #1;
        chk("lrst_ok0", {31'd0, slot0_ok}, 32'd0);
        chk("lrst_ok1", {31'd0, slot1_ok}, 32'd0);
        slot0_cs = 1'b0;

        // downloading with slot1 cached
        tick();
        chk("dl_pre_addr", {10'd0, sdram_addr}, 32'h1);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        data_rdy = 1'b1;
        data_read = 32'hC1C1C1C1;
        tick();
        data_rdy = 1'b0;
        chk("dl_pre_ok1", {31'd0, slot1_ok}, 32'd1);
        downloading = 1'b1;
        #1;
        chk("dl_refresh", {31'd0, refresh_en}, 32'd0);
        tick();
        chk("dl_ok1_drop", {31'd0, slot1_ok}, 32'd0);
        chk("dl_req0", {31'd0, sdram_req}, 32'd0);
        tick();
        chk("dl_req1", {31'd0, sdram_req}, 32'd0);
        chk("dl_refresh2", {31'd0, refresh_en}, 32'd0);
        downloading = 1'b0;
        tick();
        chk("dl_end_req", {31'd0, sdram_req}, 32'd1);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        downloading = 1'b1;
        data_rdy = 1'b1;
        data_read = 32'hD1D1D1D1;
        tick();
        data_rdy = 1'b0;
        downloading = 1'b0;
        #1;
        chk("dl_nocache", {31'd0, slot1_ok}, 32'd0);
        slot1_cs = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
